corner_median_sequencer: RTL and testbench

- Frame-rate controller that time-multiplexes one shared 5-tap median sorter across 8 corner-coordinate channels. Replaces 8 parallel combinational sorters.
- Captures one 8-coordinate sample set per frame on the VGA_VS falling edge into per-channel 5-deep histories.
- Sequences each channel through a multi-cycle odd-even transposition sort.
- Commits all 8 medians atomically so downstream warp/overlay logic never sees a torn coordinate set.

---
 rtl/corner_median_sequencer.sv | 141 ++++++++++++++
 tb/tb_corner_median_sequencer.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/corner_median_sequencer.sv
// Shared 5-tap median sorter, time-multiplexed over 8 corner-coordinate channels.
// One sample set is captured per frame; all 8 medians are committed to data_out in one cycle.
module corner_median_sequencer #(
  parameter int p_num_coordinates = 8,
  parameter int p_filter_length   = 5,
  parameter int p_bit_width_in    = 11
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic                                        VGA_VS,
  input  logic [p_num_coordinates*p_bit_width_in-1:0] data_in,
  output logic [p_num_coordinates*p_bit_width_in-1:0] data_out,
  output logic                                        frame_done,
  output logic                                        busy,
  output logic                                        primed,
  output logic                                        overrun
);

  localparam int lp_w      = p_bit_width_in;
  localparam int lp_bus_w  = p_num_coordinates * p_bit_width_in;
  localparam int lp_ch_w   = $clog2(p_num_coordinates);
  localparam int lp_pass_w = $clog2(p_filter_length);
  localparam int lp_cnt_w  = $clog2(p_filter_length + 1);
  localparam int lp_mid    = (p_filter_length - 1) / 2;

  typedef enum logic [2:0] {IDLE, LOAD, SORT, WRITE, COMMIT} state_t;

  state_t                 state;
  logic                   vs_prev;
  logic                   fe;
  logic [lp_ch_w-1:0]     ch;
  logic [lp_pass_w-1:0]   pass;
  logic [lp_cnt_w-1:0]    frame_count;
  logic                   pending;
  logic [lp_bus_w-1:0]    pend_data;
  logic [lp_bus_w-1:0]    shift_src;
  logic [lp_bus_w-1:0]    shadow;
  logic [lp_w-1:0]        hist [p_num_coordinates][p_filter_length];
  logic [lp_w-1:0]        work [p_filter_length];

  assign fe = vs_prev & ~VGA_VS;

  // A live edge always wins over a parked sample.
  always_comb begin
    shift_src = pend_data;
    if (fe) shift_src = data_in;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      // NOTE: histories and the sort scratchpad are cleared on reset because pre-prime
      // medians are defined as biased toward zero, not X.
      for (int k = 0; k < p_num_coordinates; k++)
        for (int i = 0; i < p_filter_length; i++) hist[k][i] <= '0;
      for (int i = 0; i < p_filter_length; i++) work[i] <= '0;
      state       <= IDLE;
      vs_prev     <= 1'b0;
      ch          <= '0;
      pass        <= '0;
      frame_count <= '0;
      pending     <= 1'b0;
      pend_data   <= '0;
      shadow      <= '0;
      data_out    <= '0;
      frame_done  <= 1'b0;
      busy        <= 1'b0;
      primed      <= 1'b0;
      overrun     <= 1'b0;
    end else begin
      vs_prev    <= VGA_VS;
      frame_done <= 1'b0;

      case (state)
        IDLE: begin
          if (fe || pending) begin
            for (int k = 0; k < p_num_coordinates; k++) begin
              for (int i = p_filter_length - 1; i > 0; i--) hist[k][i] <= hist[k][i-1];
              hist[k][0] <= shift_src[k*lp_w +: lp_w];
            end
            if (frame_count != lp_cnt_w'(p_filter_length)) frame_count <= frame_count + 1'b1;
            primed  <= (frame_count >= lp_cnt_w'(p_filter_length - 1));
            pending <= 1'b0;
            if (fe && pending) overrun <= 1'b1;
            ch    <= '0;
            state <= LOAD;
            busy  <= 1'b1;
          end
        end

        LOAD: begin
          for (int i = 0; i < p_filter_length; i++) work[i] <= hist[ch][i];
          pass  <= '0;
          state <= SORT;
        end

        SORT: begin
          // NOTE: non-blocking swaps read the pre-pass values, so each pass is a true
          // parallel compare-exchange stage; pairs within a pass never overlap.
          for (int i = 0; i < p_filter_length - 1; i++) begin
            if ((i[0] == pass[0]) && (work[i] > work[i+1])) begin
              work[i]   <= work[i+1];
              work[i+1] <= work[i];
            end
          end
          if (pass == lp_pass_w'(p_filter_length - 1)) state <= WRITE;
          else pass <= pass + 1'b1;
        end

        WRITE: begin
          shadow[ch*lp_w +: lp_w] <= work[lp_mid];
          if (ch == lp_ch_w'(p_num_coordinates - 1)) begin
            state <= COMMIT;
          end else begin
            ch    <= ch + 1'b1;
            state <= LOAD;
          end
        end

        COMMIT: begin
          data_out   <= shadow;
          frame_done <= 1'b1;
          state      <= IDLE;
          busy       <= 1'b0;
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase

      // Frames arriving mid-sequence are parked; only the newest survives.
      if (fe && (state != IDLE)) begin
        pend_data <= data_in;
        pending   <= 1'b1;
        if (pending) overrun <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_corner_median_sequencer.sv
// Scoreboard bench for corner_median_sequencer: a history/median model pushes expected
// commits (data and cycle), and a monitor pops and compares them on every frame_done.
module tb_corner_median_sequencer;

  localparam int W = 11;
  localparam int N = 8;
  localparam int L = 5;

  logic             clk = 1'b0;
  logic             reset;
  logic             VGA_VS;
  logic [N*W-1:0]   data_in;
  logic [N*W-1:0]   data_out;
  logic             frame_done;
  logic             busy;
  logic             primed;
  logic             overrun;

  corner_median_sequencer dut (
    .clk        (clk),
    .reset      (reset),
    .VGA_VS     (VGA_VS),
    .data_in    (data_in),
    .data_out   (data_out),
    .frame_done (frame_done),
    .busy       (busy),
    .primed     (primed),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [N*W-1:0] data;
    int             cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_done = 0;
  int   n_checks = 0;
  int   n_errors = 0;
  int   m_hist [N][L];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [N*W-1:0] act, input logic [N*W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic int median5(input int a0, a1, a2, a3, a4);
    int a [5];
    int t;
    a = '{a0, a1, a2, a3, a4};
    for (int i = 1; i < 5; i++) begin
      t = a[i];
      for (int j = i; j > 0 && a[j-1] > t; j--) begin
        a[j]   = a[j-1];
        a[j-1] = t;
      end
    end
    return a[2];
  endfunction

  function automatic logic [N*W-1:0] pack_all(input int v);
    logic [N*W-1:0] d;
    for (int k = 0; k < N; k++) d[k*W +: W] = W'(v);
    return d;
  endfunction

  task automatic model_reset();
    for (int k = 0; k < N; k++)
      for (int i = 0; i < L; i++) m_hist[k][i] = 0;
  endtask

  task automatic model_shift(input logic [N*W-1:0] d, input int exp_cyc);
    exp_t e;
    for (int k = 0; k < N; k++) begin
      for (int i = L - 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
      m_hist[k][0] = int'(d[k*W +: W]);
      e.data[k*W +: W] = W'(median5(m_hist[k][0], m_hist[k][1], m_hist[k][2],
                                    m_hist[k][3], m_hist[k][4]));
    end
    e.cyc = exp_cyc;
    exp_q.push_back(e);
  endtask

  // Raise VS for one cycle, then drop it with the new sample; t is the capture cycle.
  task automatic vs_pulse(input logic [N*W-1:0] d, output int t);
    @(negedge clk);
    VGA_VS = 1'b1;
    @(negedge clk);
    VGA_VS  = 1'b0;
    data_in = d;
    t = cyc + 1;
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300 && exp_q.size() != 0; i++) @(negedge clk);
    check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  always @(posedge clk) begin
    exp_t e;
    #1;
    if (!reset && frame_done) begin
      n_done++;
      if (exp_q.size() == 0) begin
        check("unexpected_frame_done", 1, 0);
      end else begin
        e = exp_q.pop_front();
        check("commit_data", data_out, e.data);
        check("commit_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int t, ta, tb, tc;
    int busy_seen;
    logic [N*W-1:0] d;

    // VS held low through and after reset: no capture may occur.
    reset   = 1'b1;
    VGA_VS  = 1'b0;
    data_in = pack_all(123);
    model_reset();
    repeat (3) @(negedge clk);
    reset = 1'b0;
    check("rst_data_out", data_out, 0);
    check("rst_busy", busy, 0);
    check("rst_primed", primed, 0);
    check("rst_overrun", overrun, 0);
    check("rst_frame_done", frame_done, 0);
    busy_seen = 0;
    repeat (20) begin
      @(negedge clk);
      if (busy) busy_seen = 1;
    end
    check("vs_low_no_busy", busy_seen, 0);

    // Ramp 100..500 on all channels; primed only after the fifth capture.
    for (int j = 0; j < 5; j++) begin
      d = pack_all(100 * (j + 1));
      vs_pulse(d, t);
      model_shift(d, t + 57);
      if (j == 0) begin
        @(negedge clk);
        check("busy_after_capture", busy, 1);
        while (cyc < t + 56) @(negedge clk);
        check("busy_late_sequence", busy, 1);
      end
      wait_drain();
      check($sformatf("primed_f%0d", j), primed, (j == 4));
      check($sformatf("busy_idle_f%0d", j), busy, 0);
    end
    check("ramp_ch4_median", data_out[4*W +: W], 300);
    check("ramp_done_count", n_done, 5);

    // Distinct per-channel sequences.
    for (int j = 0; j < 5; j++) begin
      int c0 [5] = '{7, 3, 9, 1, 5};
      int c7 [5] = '{2047, 0, 2047, 0, 1024};
      for (int k = 0; k < N; k++) d[k*W +: W] = W'(k * 10);
      d[0 +: W]     = W'(c0[j]);
      d[7*W +: W]   = W'(c7[j]);
      vs_pulse(d, t);
      model_shift(d, t + 57);
      wait_drain();
    end
    check("mix_ch0", data_out[0 +: W], 5);
    check("mix_ch3", data_out[3*W +: W], 30);
    check("mix_ch7", data_out[7*W +: W], 1024);

    // Spike rejection.
    for (int j = 0; j < 5; j++) begin
      d = pack_all((j == 4) ? 2000 : 50);
      vs_pulse(d, t);
      model_shift(d, t + 57);
      wait_drain();
    end
    check("spike_ch2", data_out[2*W +: W], 50);

    // One edge mid-sequence is parked and processed after commit.
    d = pack_all(600);
    vs_pulse(d, ta);
    model_shift(d, ta + 57);
    repeat (18) @(negedge clk);
    d = pack_all(77);
    vs_pulse(d, tb);
    model_shift(d, ta + 115);
    wait_drain();
    check("pending_no_overrun", overrun, 0);

    // Three edges in one sequence: middle sample lost, overrun set.
    d = pack_all(900);
    vs_pulse(d, ta);
    model_shift(d, ta + 57);
    repeat (8) @(negedge clk);
    vs_pulse(pack_all(11), tb);
    repeat (8) @(negedge clk);
    d = pack_all(1500);
    vs_pulse(d, tc);
    model_shift(d, ta + 115);
    wait_drain();
    check("triple_overrun", overrun, 1);

    // Reset mid-sequence abandons it without a commit.
    vs_pulse(pack_all(333), t);
    while (cyc < t + 30) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    check("midrst_data_out", data_out, 0);
    check("midrst_overrun", overrun, 0);
    check("midrst_busy", busy, 0);
    check("midrst_primed", primed, 0);
    check("midrst_frame_done", frame_done, 0);
    repeat (70) @(negedge clk);
    check("midrst_no_commit", data_out, 0);

    // Recovery after reset: a fresh capture yields zero-biased medians.
    d = pack_all(42);
    vs_pulse(d, t);
    model_shift(d, t + 57);
    wait_drain();
    check("recover_ch0", data_out[0 +: W], 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
